hazard_forward_unit: RTL

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

---
 rtl/hazard_forward_unit.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/hazard_forward_unit.sv
// Decode-stage hazard unit: tracks in-flight producers, forwards results to
// decode operands, raises load-use stalls and drains the pipe for FENCE.
module hazard_forward_unit #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned REG_ADDR   = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        dec_valid,
  input  logic [REG_ADDR-1:0]         dec_rd,
  input  logic                        dec_rd_we,
  input  logic                        dec_is_load,
  input  logic                        dec_is_store,
  input  logic                        dec_is_fence,
  input  logic [3:0]                  dec_fence_pred,
  input  logic [NUM_SRC*REG_ADDR-1:0] dec_rs,
  input  logic [NUM_SRC-1:0]          dec_rs_used,
  input  logic [NUM_SRC*XLEN-1:0]     dec_operand,
  input  logic [DEPTH*XLEN-1:0]       stage_result,
  input  logic                        flush,
  output logic [NUM_SRC*XLEN-1:0]     fwd_operand,
  output logic [NUM_SRC*4-1:0]        fwd_sel,
  output logic                        stall,
  output logic                        fence_busy,
  output logic [31:0]                 stall_count
);

  localparam int unsigned CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {RUN, FENCE_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [31:0]         stall_cnt_q;

  logic [DEPTH-1:0]    ent_valid_q, ent_we_q, ent_load_q, ent_store_q;
  logic [REG_ADDR-1:0] ent_rd_q [DEPTH];

  logic                lu_stall;
  logic [NUM_SRC*4-1:0]    fwd_sel_c;
  logic [NUM_SRC*XLEN-1:0] fwd_op_c;
  logic                hit, hit_load, hit_early;
  logic [3:0]          hit_sel;
  logic [XLEN-1:0]     hit_data;
  logic [REG_ADDR-1:0] rs;

  logic                f_hit, fence_det, stall_raw;
  logic [CW-1:0]       f_cnt;
  logic                pred_ld, pred_st;

  // Per-source search for the youngest matching producer and load-use check.
  always_comb begin
    lu_stall  = 1'b0;
    fwd_sel_c = '0;
    fwd_op_c  = dec_operand;
    hit       = 1'b0;
    hit_load  = 1'b0;
    hit_early = 1'b0;
    hit_sel   = '0;
    hit_data  = '0;
    rs        = '0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      hit       = 1'b0;
      hit_load  = 1'b0;
      hit_early = 1'b0;
      hit_sel   = '0;
      hit_data  = '0;
      rs        = dec_rs[s*REG_ADDR +: REG_ADDR];
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (!hit && dec_valid && dec_rs_used[s] && (rs != '0) &&
            ent_valid_q[i] && ent_we_q[i] && (ent_rd_q[i] == rs)) begin
          hit       = 1'b1;
          hit_load  = ent_load_q[i];
          hit_early = (i < LOAD_STAGE);
          hit_sel   = 4'(i + 1);
          hit_data  = stage_result[i*XLEN +: XLEN];
        end
      end
      if (hit) begin
        if (hit_load && hit_early) begin
          lu_stall = 1'b1;
        end else begin
          fwd_sel_c[s*4 +: 4]     = hit_sel;
          fwd_op_c[s*XLEN +: XLEN] = hit_data;
        end
      end
    end
  end

  // Youngest in-flight memory op ordered by the FENCE predecessor set.
  always_comb begin
    pred_ld = dec_fence_pred[1] | dec_fence_pred[3];
    pred_st = dec_fence_pred[0] | dec_fence_pred[2];
    f_hit   = 1'b0;
    f_cnt   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!f_hit && ent_valid_q[i] &&
          ((pred_ld && ent_load_q[i]) || (pred_st && ent_store_q[i]))) begin
        f_hit = 1'b1;
        f_cnt = CW'(DEPTH - 1 - i);
      end
    end
    fence_det = (state_q == RUN) && dec_valid && dec_is_fence && f_hit;
  end

  // FSM state and drain counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state; flush aborts any drain in progress.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (fence_det) begin
          cnt_d   = f_cnt;
          state_d = (f_cnt != '0) ? FENCE_DRAIN : RUN;
        end
      end
      FENCE_DRAIN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (flush) begin
      state_d = RUN;
      cnt_d   = '0;
    end
  end

  // Outputs; reset forces a transparent, non-stalling view.
  always_comb begin
    stall_raw   = lu_stall | fence_det | (state_q == FENCE_DRAIN);
    stall       = !rst && stall_raw;
    fence_busy  = !rst && (state_q == FENCE_DRAIN);
    fwd_sel     = rst ? '0 : fwd_sel_c;
    fwd_operand = rst ? dec_operand : fwd_op_c;
    stall_count = stall_cnt_q;
  end

  // Entry valid bits: shift down, bubble on stall, clear on flush.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ent_valid_q <= '0;
    end else begin
      for (int unsigned i = 1; i < DEPTH; i++) ent_valid_q[i] <= ent_valid_q[i-1];
      ent_valid_q[0] <= dec_valid && !stall;
    end
  end

  // Entry payload shift; meaningful only where the valid bit is set.
  always_ff @(posedge clk) begin
    for (int unsigned i = 1; i < DEPTH; i++) begin
      ent_rd_q[i]    <= ent_rd_q[i-1];
      ent_we_q[i]    <= ent_we_q[i-1];
      ent_load_q[i]  <= ent_load_q[i-1];
      ent_store_q[i] <= ent_store_q[i-1];
    end
    ent_rd_q[0]    <= dec_rd;
    ent_we_q[0]    <= dec_rd_we;
    ent_load_q[0]  <= dec_is_load;
    ent_store_q[0] <= dec_is_store;
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

endmodule
